word_serializer: RTL
====================

Name: word_serializer

Overview:
- Parallel-to-serial front end for the serial bit-stream detectors (multiple-of-N FSMs and similar), which consume one bit per clock on input `a`.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per cycle.
- A one-entry holding buffer allows gap-free back-to-back words.
- Frame markers let downstream logic delimit words.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH): width of the bit counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: synchronous and active-high.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block can accept a word this cycle.
- flush  input  1  synchronous abort; discards the word in flight and the buffered word.
- a  output  1  serial data bit, MSB first; connects to the downstream detector input `a`.
- bit_valid  output  1  a carries a real data bit this cycle.
- first  output  1  a is bit WIDTH-1 of a word.
- last  output  1  a is bit 0 of a word.
- busy  output  1  shifter or buffer occupied.

Behaviour:
- Registered outputs: a, bit_valid, first, last.
- Reset (rst=1 at an edge), including mid-word:
  - a=0, bit_valid=0, first=0, last=0.
  - State=IDLE, bit counter=0, buffer empty, shift register cleared.
  - rst dominates flush and din_valid.
- din_ready = !rst && !buf_full. It is combinational; no path from din_valid to din_ready.
- Accept: din_valid && din_ready at a rising edge.
- State IDLE (bit_valid=0, a=0):
  - Accept, or buffer full → load the word into the shifter and go to SHIFT. The buffer has priority if both apply; an accepted word then goes to the buffer. The buffer cannot be full in IDLE except after ...; treat the priority as a rule.
  - Latency: word accepted at edge k drives its MSB on a, with bit_valid=1 and first=1, during cycle k+1.
- State SHIFT:
  - Each edge shifts left one bit; a = current MSB; the counter increments from 0 to WIDTH-1.
  - last=1 exactly when counter=WIDTH-1. first=1 exactly when counter=0.
  - A word accepted while in SHIFT goes to the buffer (buf_full=1, so din_ready drops next cycle).
- Word boundary (edge ending the cycle in which last=1):
  - Buffer full → buffer moves to the shifter; the next MSB appears the following cycle with first=1. There is no idle gap. Buffer empties and din_ready rises that cycle.
  - Buffer empty but accept at this edge → new word loads straight into the shifter, no gap.
  - Otherwise → IDLE; bit_valid=0, a=0 next cycle.
- Throughput: with din_valid held high, output is continuous, with one word every WIDTH cycles.
- flush=1 at an edge:
  - Same effect as reset on the shifter, buffer, counter and outputs.
  - A word presented with din_valid in the same cycle is not accepted, even if din_ready=1.
  - Downstream sees bit_valid=0 from the next cycle; a partial word is never completed.
- busy = (state==SHIFT) || buf_full.
- Idle bits: the downstream detector samples a every cycle, so idle zeros are visible to it. Qualifying the detector with bit_valid/first is the integrator's responsibility.
- Data width: din is captured whole at acceptance; later changes to din do not affect a word in flight.

Test Plan:
- Single word: WIDTH=8; reset 2 cycles; din=8'hCC accepted at edge k.
  - Required a = 1,1,0,0,1,1,0,0 in cycles k+1..k+8.
  - bit_valid=1 for those 8 cycles only; first at k+1, last at k+8.
  - a=0 and bit_valid=0 at k+9.
- Back-to-back: din_valid held high with 8'hA5 then 8'h3C.
  - 16 contiguous valid bits: 10100101 00111100.
  - din_ready=0 while the buffer holds 8'h3C.
  - Exactly 2 accepts; no gap between the last of word 1 and the first of word 2.
- Back-pressure: three words offered continuously.
  - Third word is accepted only on the cycle after word 2 moves from buffer to shifter.
  - All 24 bits appear in order.
- Flush mid-word: flush at 4th bit of 8'hF0 while buffer holds 8'h0F.
  - Next cycle: bit_valid=0, busy=0, din_ready=1.
  - Neither word's remaining bits ever appear.
- Reset mid-word: rst=1 at 3rd bit of a word.
  - All outputs 0 and din_ready=0 while rst=1.
  - After release, din_ready=1, and a new word 8'h04 serializes as 00000100 with correct first/last.
- Detector integration: 8'h0C then 8'h0D fed to the multiple-of-four detector.
  - Detector y=1 sampled at last of 8'h0C; y=0 at last of 8'h0D.

Source files
------------

// File: rtl/word_serializer.sv
// word_serializer: accepts WIDTH-bit words over valid/ready and shifts them
// out MSB-first, one bit per clock, with first/last frame markers. A
// one-entry holding buffer lets consecutive words leave with no idle gap.
module word_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush,
    output logic             a,
    output logic             bit_valid,
    output logic             first,
    output logic             last,
    output logic             busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(WIDTH - 2);

    state_t             r_state;
    // Bits still to be sent after the one currently on a, MSB-aligned.
    logic [WIDTH-2:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_buf;
    logic               r_buf_full;
    logic               r_a;
    logic               r_bit_valid;
    logic               r_first;
    logic               r_last;

    logic               w_din_ready;
    logic               w_accept;
    logic               w_word_end;
    logic               w_load_from_buf;
    logic               w_load_from_din;
    logic               w_load;
    logic [WIDTH-1:0]   w_load_word;

    assign w_din_ready = !rst && !r_buf_full;
    assign w_accept    = din_valid && w_din_ready;
    assign w_word_end  = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);

    // Pick what enters the shifter at a word boundary: the buffer first, else a fresh word.
    always_comb begin
        w_load_from_buf = 1'b0;
        w_load_from_din = 1'b0;
        w_load_word     = r_buf;
        if ((r_state == S_IDLE) || w_word_end) begin
            if (r_buf_full) begin
                w_load_from_buf = 1'b1;
                w_load_word     = r_buf;
            end else if (w_accept) begin
                w_load_from_din = 1'b1;
                w_load_word     = din;
            end
        end
        w_load = w_load_from_buf || w_load_from_din;
    end

    // Serializer FSM: buffer bookkeeping, shifter, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_buf_full  <= 1'b0;
            r_a         <= 1'b0;
            r_bit_valid <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            // An accepted word that does not go straight to the shifter parks in the buffer.
            if (w_accept && !w_load_from_din) begin
                r_buf <= din;
            end
            r_buf_full <= (r_buf_full && !w_load_from_buf) || (w_accept && !w_load_from_din);

            if (w_load) begin
                r_state     <= S_SHIFT;
                r_shift     <= w_load_word[WIDTH-2:0];
                r_a         <= w_load_word[WIDTH-1];
                r_cnt       <= '0;
                r_bit_valid <= 1'b1;
                r_first     <= 1'b1;
                r_last      <= 1'b0;
            end else if ((r_state == S_SHIFT) && !w_word_end) begin
                r_shift     <= r_shift << 1;
                r_a         <= r_shift[WIDTH-2];
                r_cnt       <= r_cnt + CNT_W'(1);
                r_bit_valid <= 1'b1;
                r_first     <= 1'b0;
                r_last      <= (r_cnt == PRE_LAST_CNT);
            end else begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_a         <= 1'b0;
                r_bit_valid <= 1'b0;
                r_first     <= 1'b0;
                r_last      <= 1'b0;
            end
        end
    end

    assign din_ready = w_din_ready;
    assign a         = r_a;
    assign bit_valid = r_bit_valid;
    assign first     = r_first;
    assign last      = r_last;
    assign busy      = (r_state == S_SHIFT) || r_buf_full;

endmodule
